axis_tone_sequencer: RTL and testbench

Control block for the NCO → MASH 1-1 → DSM DAC chain. It steps the NCO through a programmed list of phase-step words, holding each for a programmed number of output samples. Each new step word is pushed over an AXI-Stream master port into the NCO step input. This gives frequency sweeps and multi-tone bursts without a processor in the loop. At the end of a run, and on stop, it drives a zero step to silence the chain.

---
 rtl/axis_tone_sequencer.sv | 178 +++++++++++++++++
 tb/tb_axis_tone_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tone_sequencer.sv
// Tone-table sequencer: walks the NCO through programmed step words over AXI-Stream,
// holding each for a programmed number of DAC samples, then silences it with a zero step.
module axis_tone_sequencer #(
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned DWELL_WIDTH = 24
) (
   input  logic                       aclk,
   input  logic                       arst,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [ACC_WIDTH-1:0]       cfg_step,
   input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
   input  logic [$clog2(DEPTH)-1:0]   cfg_last,
   input  logic                       cfg_loop,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       sample_tick,
   output logic [ACC_WIDTH-1:0]       m_axis_step_tdata,
   output logic                       m_axis_step_tvalid,
   input  logic                       m_axis_step_tready,
   output logic                       busy,
   output logic [$clog2(DEPTH)-1:0]   tone_idx,
   output logic                       done
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PRESENT,
      S_DWELL,
      S_FINISH
   } state_t;

   logic [ACC_WIDTH-1:0]   tbl_step  [DEPTH];
   logic [DWELL_WIDTH-1:0] tbl_dwell [DEPTH];

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_d, last_q, last_d;
   logic                   loop_q, loop_d;
   logic                   pend_q, pend_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d, cnt_inc, dwell_eff;
   logic [ACC_WIDTH-1:0]   tdata_d;
   logic                   tvalid_d, busy_d, done_d, hs;

   // Tone table; writes land immediately and are picked up at the entry's next load
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl_step[i]  <= '0;
            tbl_dwell[i] <= '0;
         end
      end else if (cfg_we) begin
         tbl_step[cfg_addr]  <= cfg_step;
         tbl_dwell[cfg_addr] <= cfg_dwell;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      idx_d     = tone_idx;
      last_d    = last_q;
      loop_d    = loop_q;
      pend_d    = pend_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      tdata_d   = m_axis_step_tdata;
      tvalid_d  = m_axis_step_tvalid;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      hs        = m_axis_step_tvalid && m_axis_step_tready;
      cnt_inc   = cnt_q + 1'b1;
      dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               last_d  = cfg_last;
               loop_d  = cfg_loop;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            tvalid_d = 1'b1;
            if (stop) begin
               tdata_d = '0;
               state_d = S_FINISH;
            end else begin
               tdata_d = tbl_step[tone_idx];
               dwell_d = tbl_dwell[tone_idx];
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            // tvalid is never withdrawn; a stop here waits for the handshake
            if (stop) pend_d = 1'b1;
            if (hs) begin
               pend_d = 1'b0;
               if (pend_q || stop) begin
                  tdata_d = '0;
                  state_d = S_FINISH;
               end else begin
                  tvalid_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = S_DWELL;
               end
            end
         end
         S_DWELL: begin
            if (stop) begin
               tvalid_d = 1'b1;
               tdata_d  = '0;
               state_d  = S_FINISH;
            end else if (sample_tick) begin
               if (cnt_inc == dwell_eff) begin
                  if (tone_idx != last_q) begin
                     idx_d   = IDX_W'(tone_idx + 1'b1);
                     state_d = S_LOAD;
                  end else if (loop_q) begin
                     idx_d   = '0;
                     state_d = S_LOAD;
                  end else begin
                     tvalid_d = 1'b1;
                     tdata_d  = '0;
                     state_d  = S_FINISH;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_FINISH: begin
            if (hs) begin
               tvalid_d = 1'b0;
               tdata_d  = '0;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q            <= S_IDLE;
         tone_idx           <= '0;
         last_q             <= '0;
         loop_q             <= 1'b0;
         pend_q             <= 1'b0;
         dwell_q            <= '0;
         cnt_q              <= '0;
         m_axis_step_tdata  <= '0;
         m_axis_step_tvalid <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         state_q            <= state_d;
         tone_idx           <= idx_d;
         last_q             <= last_d;
         loop_q             <= loop_d;
         pend_q             <= pend_d;
         dwell_q            <= dwell_d;
         cnt_q              <= cnt_d;
         m_axis_step_tdata  <= tdata_d;
         m_axis_step_tvalid <= tvalid_d;
         busy               <= busy_d;
         done               <= done_d;
      end
   end

endmodule

// File: tb/tb_axis_tone_sequencer.sv
// Scoreboard bench for axis_tone_sequencer: directed runs queue the expected stream beats
// and done pulses; a negedge monitor pops and checks them whenever the DUT presents one.
module tb_axis_tone_sequencer;
   localparam int unsigned ACC_W = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW_W  = 24;
   localparam int unsigned IDX_W = 3;

   logic              aclk = 1'b0;
   logic              arst = 1'b1;
   logic              cfg_we = 1'b0;
   logic [IDX_W-1:0]  cfg_addr = '0;
   logic [ACC_W-1:0]  cfg_step = '0;
   logic [DW_W-1:0]   cfg_dwell = '0;
   logic [IDX_W-1:0]  cfg_last = '0;
   logic              cfg_loop = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              sample_tick = 1'b0;
   logic [ACC_W-1:0]  m_axis_step_tdata;
   logic              m_axis_step_tvalid;
   logic              m_axis_step_tready = 1'b1;
   logic              busy;
   logic [IDX_W-1:0]  tone_idx;
   logic              done;

   axis_tone_sequencer #(.ACC_WIDTH(ACC_W), .DEPTH(DEPTH), .DWELL_WIDTH(DW_W)) dut (
      .aclk(aclk), .arst(arst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_last(cfg_last), .cfg_loop(cfg_loop), .start(start),
      .stop(stop), .sample_tick(sample_tick), .m_axis_step_tdata(m_axis_step_tdata),
      .m_axis_step_tvalid(m_axis_step_tvalid), .m_axis_step_tready(m_axis_step_tready),
      .busy(busy), .tone_idx(tone_idx), .done(done));

   always #5 aclk = ~aclk;

   typedef struct {
      logic [ACC_W-1:0] data;
      int               idx;
      int               cyc;
   } beat_t;

   beat_t hs_q[$];
   int    done_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    last_hs = 0;
   int    tick_mode = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   // Monitor: every handshake and every done pulse must match the head of its queue
   always @(negedge aclk) begin
      beat_t e;
      int    dc;
      if (!arst && m_axis_step_tvalid && m_axis_step_tready) begin
         last_hs = cyc;
         n_vec++;
         if (hs_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got data=%0d idx=%0d cyc=%0d, required no beat",
                     m_axis_step_tdata, tone_idx, cyc);
         end else begin
            e = hs_q.pop_front();
            if (m_axis_step_tdata !== e.data || int'(tone_idx) != e.idx || cyc != e.cyc) begin
               n_err++;
               $display("FAIL beat: got data=%0d idx=%0d cyc=%0d, required data=%0d idx=%0d cyc=%0d",
                        m_axis_step_tdata, tone_idx, cyc, e.data, e.idx, e.cyc);
            end
         end
      end
      if (!arst && done) begin
         n_vec++;
         if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected: got done at cyc=%0d, required none", cyc);
         end else begin
            dc = done_q.pop_front();
            if (cyc != dc || busy !== 1'b0) begin
               n_err++;
               $display("FAIL done: got cyc=%0d busy=%0b, required cyc=%0d busy=0", cyc, busy, dc);
            end
         end
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
      case (tick_mode)
         0:       sample_tick = 1'b0;
         1:       sample_tick = 1'b1;
         default: sample_tick = ((cyc - last_hs) > 0) && (((cyc - last_hs) % 4) == 0);
      endcase
   endtask

   task automatic steps(int n);
      repeat (n) step();
   endtask

   task automatic wr(int a, logic [ACC_W-1:0] s, logic [DW_W-1:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = IDX_W'(a);
      cfg_step  = s;
      cfg_dwell = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic go(output int s);
      s     = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic push(logic [ACC_W-1:0] d, int idx, int c);
      beat_t b;
      b.data = d;
      b.idx  = idx;
      b.cyc  = c;
      hs_q.push_back(b);
   endtask

   task automatic drain(string nm);
      chk({nm, "_beats_left"}, 64'(hs_q.size()), 64'd0);
      chk({nm, "_done_left"}, 64'(done_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      steps(2);
      chk("rst_tvalid", 64'(m_axis_step_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_axis_step_tdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_idx", 64'(tone_idx), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      arst = 1'b0;
      step();

      // Single tone, tick every cycle; a start while busy must be ignored
      wr(0, 32'd85900, 24'd4);
      cfg_last = '0; cfg_loop = 1'b0; tick_mode = 1; m_axis_step_tready = 1'b1;
      go(s);
      push(32'd85900, 0, s + 2); push(32'd0, 0, s + 7); done_q.push_back(s + 8);
      chk("single_busy", 64'(busy), 64'd1);
      steps(2);
      chk("single_tvalid_1cyc", 64'(m_axis_step_tvalid), 64'd0);
      start = 1'b1; step(); start = 1'b0;
      steps(6);
      chk("single_busy_end", 64'(busy), 64'd0);
      drain("single");

      // Three-tone sweep, tick every 4th cycle; entry 1 rewritten while tone 0 plays
      wr(0, 32'd85900, 24'd3); wr(1, 32'd999, 24'd2); wr(2, 32'd343600, 24'd1);
      cfg_last = 3'd2; tick_mode = 2;
      go(s);
      push(32'd85900, 0, s + 2); push(32'd171800, 1, s + 16);
      push(32'd343600, 2, s + 26); push(32'd0, 2, s + 31); done_q.push_back(s + 32);
      steps(4);
      wr(1, 32'd171800, 24'd2);
      steps(34);
      drain("sweep");

      // Backpressure: ten stalled PRESENT cycles, ticks there must not count
      wr(0, 32'h1234_5678, 24'd2);
      cfg_last = '0; tick_mode = 1; m_axis_step_tready = 1'b0;
      go(s);
      push(32'h1234_5678, 0, s + 12); push(32'd0, 0, s + 15); done_q.push_back(s + 16);
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_tvalid", 64'(m_axis_step_tvalid), 64'd1);
         chk("bp_tdata", 64'(m_axis_step_tdata), 64'h1234_5678);
         step();
      end
      m_axis_step_tready = 1'b1;
      steps(8);
      drain("bp");

      // Loop 0,1,0 then stop in the third dwell
      wr(0, 32'd1000, 24'd2); wr(1, 32'd2000, 24'd3);
      cfg_last = 3'd1; cfg_loop = 1'b1;
      go(s);
      push(32'd1000, 0, s + 2); push(32'd2000, 1, s + 6); push(32'd1000, 0, s + 11);
      push(32'd0, 0, s + 13); done_q.push_back(s + 14);
      steps(11);
      stop = 1'b1; step(); stop = 1'b0;
      steps(8);
      drain("loop_stop");

      // Stop during a stalled PRESENT waits for that handshake
      m_axis_step_tready = 1'b0;
      go(s);
      push(32'd1000, 0, s + 5); push(32'd0, 0, s + 6); done_q.push_back(s + 7);
      steps(2);
      stop = 1'b1; step(); stop = 1'b0;
      chk("pend_tvalid", 64'(m_axis_step_tvalid), 64'd1);
      chk("pend_tdata", 64'(m_axis_step_tdata), 64'd1000);
      step();
      m_axis_step_tready = 1'b1;
      step();
      chk("pend_finish_tdata", 64'(m_axis_step_tdata), 64'd0);
      steps(6);
      drain("pend");

      // Dwell of zero behaves as one
      wr(0, 32'd77, 24'd0);
      cfg_last = '0; cfg_loop = 1'b0;
      go(s);
      push(32'd77, 0, s + 2); push(32'd0, 0, s + 4); done_q.push_back(s + 5);
      steps(8);
      drain("dwell0");

      // Start together with stop stays idle
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 64'(busy), 64'd0);
      step();
      chk("startstop_busy2", 64'(busy), 64'd0);
      chk("startstop_tvalid", 64'(m_axis_step_tvalid), 64'd0);

      // Async reset in a stalled PRESENT, then a run from the cleared table
      wr(0, 32'd555, 24'd3);
      m_axis_step_tready = 1'b0;
      go(s);
      step();
      chk("pre_rst_tvalid", 64'(m_axis_step_tvalid), 64'd1);
      #2 arst = 1'b1;
      #1;
      chk("arst_tvalid", 64'(m_axis_step_tvalid), 64'd0);
      chk("arst_tdata", 64'(m_axis_step_tdata), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_idx", 64'(tone_idx), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      step();
      arst = 1'b0;
      m_axis_step_tready = 1'b1;
      step();
      go(s);
      push(32'd0, 0, s + 2); push(32'd0, 0, s + 4); done_q.push_back(s + 5);
      steps(8);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
